// File: rtl/traffic_light_if.sv
// Two-way traffic light bus. Each direction is one-hot {G,Y,R}.
// The light controller drives the bus and the monitor only observes it.
// Handshake: there is none. The bus is a level-sampled status bus with no
// valid/ready pair. The observer samples both directions on every rising
// clock edge.
interface traffic_light_if;
  logic [2:0] light1;
  logic [2:0] light2;

  modport master (output light1, output light2);
  modport slave  (input  light1, input  light2);
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive monitor for a two-way traffic light controller.
// It decodes the intersection phase and flags unsafe patterns, out-of-order
// phases and dwell times outside the tolerance. All outputs are registered,
// so each one reflects the lights sampled at the previous clock edge.
module traffic_light_monitor #(
  parameter logic [31:0] CNTMAX = 32'd100000000,
  parameter logic [31:0] TOL    = 32'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_light_if.slave        lights,
  output logic [2:0]            phase,
  output logic                  locked,
  output logic                  conflict,
  output logic                  conflict_seen,
  output logic                  seq_err,
  output logic                  timing_err,
  output logic [7:0]            err_cnt
);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_e;
  typedef enum logic [2:0] {
    PAT_G2 = 3'd0, PAT_Y2 = 3'd1, PAT_RR = 3'd2,
    PAT_G1 = 3'd3, PAT_Y1 = 3'd4, PAT_ILL = 3'd7
  } pat_e;

  localparam logic [2:0]  C_G      = 3'b100;
  localparam logic [2:0]  C_Y      = 3'b010;
  localparam logic [2:0]  C_R      = 3'b001;
  localparam logic [2:0]  PH_NONE  = 3'd7;
  localparam logic [31:0] STEP     = CNTMAX + 32'd1;
  localparam logic [31:0] STEP_G1  = STEP << 1;
  localparam logic [31:0] DWELL_MX = 32'hFFFF_FFFF;

  // Bus pattern expected while the intersection is in a given phase.
  function automatic pat_e phase_pat(input logic [2:0] p);
    case (p)
      3'd0:    return PAT_G2;
      3'd1:    return PAT_Y2;
      3'd2:    return PAT_RR;
      3'd3:    return PAT_G1;
      3'd4:    return PAT_Y1;
      3'd5:    return PAT_RR;
      default: return PAT_ILL;
    endcase
  endfunction

  // Phase entered by an in-sequence pattern transition. The predecessor tells
  // the two all-red phases apart. Any other transition returns PH_NONE.
  function automatic logic [2:0] entry_phase(input pat_e prev, input pat_e cur);
    if      (prev == PAT_G2 && cur == PAT_Y2) return 3'd1;
    else if (prev == PAT_Y2 && cur == PAT_RR) return 3'd2;
    else if (prev == PAT_RR && cur == PAT_G1) return 3'd3;
    else if (prev == PAT_G1 && cur == PAT_Y1) return 3'd4;
    else if (prev == PAT_Y1 && cur == PAT_RR) return 3'd5;
    else if (prev == PAT_RR && cur == PAT_G2) return 3'd0;
    else                                      return PH_NONE;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [5:0]  raw_q;
  pat_e        pat_q, pat_cur;
  logic [31:0] dwell_q, dwell_d;
  logic        conflict_q, conflict_cur;
  logic        seen_q;
  logic        seq_err_q, seq_err_d;
  logic        timing_err_q, timing_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        changed;
  logic [2:0]  next_ph;
  logic [31:0] exp_dwell, lo_lim, hi_lim;
  logic [8:0]  err_sum;

  // Decode the current bus sample into a pattern and a safety verdict.
  always_comb begin
    pat_cur = PAT_ILL;
    case ({lights.light1, lights.light2})
      {C_R, C_G}: pat_cur = PAT_G2;
      {C_R, C_Y}: pat_cur = PAT_Y2;
      {C_R, C_R}: pat_cur = PAT_RR;
      {C_G, C_R}: pat_cur = PAT_G1;
      {C_Y, C_R}: pat_cur = PAT_Y1;
      default:    pat_cur = PAT_ILL;
    endcase
    conflict_cur = !$onehot(lights.light1) || !$onehot(lights.light2) ||
                   (!lights.light1[0] && !lights.light2[0]);
  end

  // Next-state logic: dwell tracking, locking, sequence and timing checks.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    seq_err_d    = 1'b0;
    timing_err_d = 1'b0;
    changed      = ({lights.light1, lights.light2} != raw_q);
    next_ph      = (phase_q == 3'd5) ? 3'd0 : 3'(phase_q + 3'd1);
    exp_dwell    = (phase_q == 3'd3) ? STEP_G1 : STEP;
    lo_lim       = (exp_dwell > TOL) ? (exp_dwell - TOL) : 32'd0;
    hi_lim       = exp_dwell + TOL;
    if (changed)                   dwell_d = 32'd1;
    else if (dwell_q == DWELL_MX)  dwell_d = dwell_q;
    else                           dwell_d = dwell_q + 32'd1;

    case (state_q)
      ST_UNLOCKED: begin
        // The segment that ends here is partial, so it is not timed.
        if (changed && entry_phase(pat_q, pat_cur) != PH_NONE) begin
          state_d = ST_LOCKED;
          phase_d = entry_phase(pat_q, pat_cur);
        end
      end
      ST_LOCKED: begin
        if (changed) begin
          if (pat_cur == PAT_ILL) begin
            state_d = ST_UNLOCKED;
          end else if (pat_cur != phase_pat(next_ph)) begin
            seq_err_d = 1'b1;
            state_d   = ST_UNLOCKED;
          end else begin
            phase_d = next_ph;
            if (dwell_q < lo_lim || dwell_q > hi_lim) timing_err_d = 1'b1;
          end
        end else if (dwell_d == hi_lim + 32'd1) begin
          // The controller stalled. Report it once and drop out of lock.
          timing_err_d = 1'b1;
          state_d      = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase

    err_sum   = {1'b0, err_cnt_q} + {8'd0, conflict_cur & ~conflict_q} +
                {8'd0, seq_err_d} + {8'd0, timing_err_d};
    err_cnt_d = (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
  end

  // State register. Reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      phase_q      <= 3'd0;
      raw_q        <= 6'd0;
      pat_q        <= PAT_ILL;
      dwell_q      <= 32'd0;
      conflict_q   <= 1'b0;
      seen_q       <= 1'b0;
      seq_err_q    <= 1'b0;
      timing_err_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      raw_q        <= {lights.light1, lights.light2};
      pat_q        <= pat_cur;
      dwell_q      <= dwell_d;
      conflict_q   <= conflict_cur;
      seen_q       <= seen_q | conflict_cur;
      seq_err_q    <= seq_err_d;
      timing_err_q <= timing_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign locked        = (state_q == ST_LOCKED);
  assign phase         = locked ? phase_q : PH_NONE;
  assign conflict      = conflict_q;
  assign conflict_seen = seen_q;
  assign seq_err       = seq_err_q;
  assign timing_err    = timing_err_q;
  assign err_cnt       = err_cnt_q;

endmodule
